// File: rtl/addsub_acc_ctrl_pkg.sv
// Shared opcode and FSM state encodings for the accumulator controller
// that drives the external ripple adder/subtractor.
package addsub_acc_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_CLR  = 2'b00,
      OP_LOAD = 2'b01,
      OP_ADD  = 2'b10,
      OP_SUB  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // ADD and SUB are the only opcodes that go through the adder.
   function automatic logic is_arith(op_e op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/addsub_acc_ctrl_if.sv
// Request/response handshake bundle between an upstream client and the
// accumulator controller. The client holds the master modport.
interface addsub_acc_ctrl_if #(
   parameter int WIDTH = 4
);
   import addsub_acc_ctrl_pkg::*;

   logic             in_valid;
   logic             in_ready;
   op_e              op;
   logic [WIDTH-1:0] d;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output in_valid, op, d, out_ready,
      input  in_ready, out_valid
   );

   modport slave (
      input  in_valid, op, d, out_ready,
      output in_ready, out_valid
   );

endinterface

// File: rtl/addsub_acc_ctrl_sat_unit.sv
// Next-accumulator selection from the adder result. With ADDSUB_SATURATE_EN
// defined, a signed overflow clamps to the extreme value; otherwise S wraps.
module addsub_sat_unit #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] s,
   input  logic             v,
   output logic [WIDTH-1:0] acc_next
);

`ifdef ADDSUB_SATURATE_EN
   // On overflow the sign of S is inverted from the true result, so a
   // negative-looking S means the real answer overflowed positive.
   always_comb begin
      acc_next = s;
      if (v) begin
         acc_next = s[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                               : {1'b1, {(WIDTH-1){1'b0}}};
      end
   end
`else
   logic unused_v;
   assign unused_v = v;
   assign acc_next = s;
`endif

endmodule

// File: rtl/addsub_acc_ctrl.sv
// Accumulator controller: accepts CLR/LOAD/ADD/SUB requests, drives the
// external adder, captures S/C/V. Optional saturation via ADDSUB_SATURATE_EN.
module addsub_acc_ctrl
   import addsub_acc_ctrl_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   addsub_acc_ctrl_if.slave   bus,
   output logic [WIDTH-1:0]   a,
   output logic [WIDTH-1:0]   b,
   output logic               m,
   output logic               c0,
   input  logic [WIDTH-1:0]   s,
   input  logic               c,
   input  logic               v,
   output logic [WIDTH-1:0]   acc,
   output logic               carry_flag,
   output logic               ovf_flag,
   output logic               ovf_sticky,
   output logic [CNT_W-1:0]   op_count
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, b_q, acc_exec;
   logic             m_q, carry_q, ovf_q, sticky_q;
   logic [CNT_W-1:0] cnt_q;
   logic             accept, exec_end;

   addsub_sat_unit #(.WIDTH(WIDTH)) u_sat (
      .s        (s),
      .v        (v),
      .acc_next (acc_exec)
   );

   // NOTE: every output of this block gets a default before the case so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d       = state_q;
      accept        = 1'b0;
      exec_end      = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // The state register already reads IDLE during reset, so ready
            // is masked explicitly to stay low until reset releases.
            bus.in_ready = rst_n;
            if (bus.in_valid) begin
               accept  = 1'b1;
               state_d = is_arith(bus.op) ? ST_EXEC : ST_DONE;
            end
         end
         ST_EXEC: begin
            exec_end = 1'b1;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         b_q      <= '0;
         m_q      <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            b_q <= bus.d;
            m_q <= (bus.op == OP_SUB);
            case (bus.op)
               OP_CLR: begin
                  acc_q    <= '0;
                  carry_q  <= 1'b0;
                  ovf_q    <= 1'b0;
                  sticky_q <= 1'b0;
               end
               OP_LOAD: acc_q <= bus.d;
               default: ;
            endcase
         end
         // The adder has had the whole EXEC cycle to settle on ACC and B.
         if (exec_end) begin
            acc_q    <= acc_exec;
            carry_q  <= c;
            ovf_q    <= v;
            sticky_q <= sticky_q | v;
            cnt_q    <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign a          = acc_q;
   assign b          = b_q;
   assign m          = m_q;
   assign c0         = m_q;
   assign acc        = acc_q;
   assign carry_flag = carry_q;
   assign ovf_flag   = ovf_q;
   assign ovf_sticky = sticky_q;
   assign op_count   = cnt_q;

endmodule

// File: tb/tb_addsub_acc_ctrl.sv
// Bench for addsub_acc_ctrl with a behavioural model of the ripple adder;
// honours ADDSUB_SATURATE_EN in its expected values.
module tb_addsub_acc_ctrl;
   import addsub_acc_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] a, b, s, acc;
   logic       m, c0, c, v, carry_flag, ovf_flag, ovf_sticky;
   logic [7:0] op_count;
   logic [4:0] add_full;

   always #5 clk = ~clk;

   addsub_acc_ctrl_if #(.WIDTH(4)) bus ();

   addsub_acc_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .a          (a),
      .b          (b),
      .m          (m),
      .c0         (c0),
      .s          (s),
      .c          (c),
      .v          (v),
      .acc        (acc),
      .carry_flag (carry_flag),
      .ovf_flag   (ovf_flag),
      .ovf_sticky (ovf_sticky),
      .op_count   (op_count)
   );

   // External adder: A + (B xor M) + C0.
   assign add_full = {1'b0, a} + {1'b0, b ^ {4{m}}} + {4'b0, c0};
   assign s        = add_full[3:0];
   assign c        = add_full[4];
   assign v        = (a[3] == (b[3] ^ m)) && (s[3] != a[3]);

`ifdef ADDSUB_SATURATE_EN
   localparam logic [3:0] OVF_POS = 4'h7;
   localparam logic [3:0] OVF_NEG = 4'h8;
`else
   localparam logic [3:0] OVF_POS = 4'h8;
   localparam logic [3:0] OVF_NEG = 4'h7;
`endif

   typedef struct {
      op_e        op;
      logic [3:0] d;
      logic [3:0] acc;
      logic       cf;
      logic       of;
      logic       st;
      logic [7:0] cnt;
   } vec_t;

   typedef struct {
      op_e        op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] acc;
      logic       cf;
      logic       of;
      logic       st;
      logic [7:0] cnt;
   } exp_t;

   vec_t       vecs [14];
   exp_t       sb_q [$];
   logic [3:0] last_acc;
   int         checks = 0;
   int         errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input op_e op, input logic [3:0] d, input logic [3:0] r,
                           input logic cf, input logic of, input logic st, input logic [7:0] cnt);
      exp_t e;
      e.op = op; e.a = last_acc; e.b = d; e.acc = r;
      e.cf = cf; e.of = of; e.st = st; e.cnt = cnt;
      sb_q.push_back(e);
      last_acc = r;
   endtask

   // Presents a request and returns just after the edge that accepts it.
   task automatic drive_accept(input op_e op, input logic [3:0] d);
      int n;
      @(negedge clk);
      bus.op = op; bus.d = d; bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", {31'b0, bus.in_ready}, 1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   // Waits for the result, pops the scoreboard and completes the handshake.
   task automatic receive();
      exp_t e;
      int   lat;
      bit   arith;
      lat   = 0;
      arith = 1'b0;
      if (sb_q.size() > 0) arith = is_arith(sb_q[0].op);
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1 && arith) begin
            check("exec_a", a, sb_q[0].a);
            check("exec_b", b, sb_q[0].b);
            check("exec_m", m, sb_q[0].op == OP_SUB);
            check("exec_c0", c0, sb_q[0].op == OP_SUB);
            check("exec_in_ready", bus.in_ready, 0);
         end
      end while (!bus.out_valid && lat < 10);
      check("latency", lat, arith ? 2 : 1);
      check("sb_nonempty", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("acc", acc, e.acc);
         check("carry_flag", carry_flag, e.cf);
         check("ovf_flag", ovf_flag, e.of);
         check("ovf_sticky", ovf_sticky, e.st);
         check("op_count", op_count, e.cnt);
         check("done_in_ready", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      check("out_valid_drop", bus.out_valid, 0);
      check("idle_in_ready", bus.in_ready, 1);
   endtask

   function automatic void model_exec(input logic [3:0] p, input logic [3:0] d, input bit sub,
                                      output logic [3:0] r, output logic cf, output logic of);
      int sp, sd, sr;
      sp = $signed(p);
      sd = $signed(d);
      sr = sub ? sp - sd : sp + sd;
      of = (sr > 7) || (sr < -8);
      cf = sub ? (p >= d) : ((int'(p) + int'(d)) > 15);
      r  = sr[3:0];
`ifdef ADDSUB_SATURATE_EN
      if (of) r = (sr > 7) ? 4'h7 : 4'h8;
`endif
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      last_acc = 4'h0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] mr;
      logic       mcf, mof, mst;

      vecs[0]  = '{OP_LOAD, 4'h3, 4'h3,    1'b0, 1'b0, 1'b0, 8'd0};
      vecs[1]  = '{OP_ADD,  4'h4, 4'h7,    1'b0, 1'b0, 1'b0, 8'd1};
      vecs[2]  = '{OP_LOAD, 4'h7, 4'h7,    1'b0, 1'b0, 1'b0, 8'd1};
      vecs[3]  = '{OP_ADD,  4'h1, OVF_POS, 1'b0, 1'b1, 1'b1, 8'd2};
      vecs[4]  = '{OP_LOAD, 4'h2, 4'h2,    1'b0, 1'b1, 1'b1, 8'd2};
      vecs[5]  = '{OP_SUB,  4'h3, 4'hF,    1'b0, 1'b0, 1'b1, 8'd3};
      vecs[6]  = '{OP_SUB,  4'h1, 4'hE,    1'b1, 1'b0, 1'b1, 8'd4};
      vecs[7]  = '{OP_CLR,  4'h9, 4'h0,    1'b0, 1'b0, 1'b0, 8'd4};
      vecs[8]  = '{OP_ADD,  4'h5, 4'h5,    1'b0, 1'b0, 1'b0, 8'd5};
      vecs[9]  = '{OP_SUB,  4'h7, 4'hE,    1'b0, 1'b0, 1'b0, 8'd6};
      vecs[10] = '{OP_ADD,  4'h3, 4'h1,    1'b1, 1'b0, 1'b0, 8'd7};
      vecs[11] = '{OP_LOAD, 4'h8, 4'h8,    1'b1, 1'b0, 1'b0, 8'd7};
      vecs[12] = '{OP_SUB,  4'h1, OVF_NEG, 1'b1, 1'b1, 1'b1, 8'd8};
      vecs[13] = '{OP_CLR,  4'h0, 4'h0,    1'b0, 1'b0, 1'b0, 8'd8};

      bus.in_valid = 1'b0; bus.op = OP_CLR; bus.d = 4'h0; bus.out_ready = 1'b0;
      last_acc = 4'h0;
      rst_n = 1'b0;
      #12;
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_acc", acc, 0);
      check("rst_b", b, 0);
      check("rst_m", m, 0);
      check("rst_flags", {carry_flag, ovf_flag, ovf_sticky}, 0);
      check("rst_op_count", op_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", bus.in_ready, 1);

      // Table-driven main sequence.
      for (int i = 0; i < 14; i++) begin
         push_exp(vecs[i].op, vecs[i].d, vecs[i].acc, vecs[i].cf, vecs[i].of, vecs[i].st, vecs[i].cnt);
         drive_accept(vecs[i].op, vecs[i].d);
         receive();
      end

      // Result held in DONE while a new request waits upstream.
      push_exp(OP_ADD, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 8'd9);
      drive_accept(OP_ADD, 4'h1);
      @(negedge clk);
      @(negedge clk);
      push_exp(OP_LOAD, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 8'd9);
      bus.op = OP_LOAD; bus.d = 4'hF; bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("hold_in_ready", bus.in_ready, 0);
         check("hold_out_valid", bus.out_valid, 1);
         check("hold_acc", acc, 4'h1);
         check("hold_b", b, 4'h1);
         @(negedge clk);
      end
      if (sb_q.size() > 0) begin
         check("hold_sb_acc", acc, sb_q[0].acc);
         check("hold_sb_cnt", op_count, sb_q[0].cnt);
         void'(sb_q.pop_front());
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      check("hold_idle_in_ready", bus.in_ready, 1);
      check("hold_idle_out_valid", bus.out_valid, 0);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      receive();
      check("held_req_b", b, 4'hF);

      // Reset during EXEC after an overflow has set the sticky flag.
      push_exp(OP_LOAD, 4'h7, 4'h7, 1'b0, 1'b0, 1'b0, 8'd9);
      drive_accept(OP_LOAD, 4'h7);
      receive();
      push_exp(OP_ADD, 4'h1, OVF_POS, 1'b0, 1'b1, 1'b1, 8'd10);
      drive_accept(OP_ADD, 4'h1);
      receive();
      drive_accept(OP_ADD, 4'h1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_acc", acc, 0);
      check("midrst_ab", {a, b}, 0);
      check("midrst_m_c0", {m, c0}, 0);
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_in_ready", bus.in_ready, 0);
      check("midrst_flags", {carry_flag, ovf_flag, ovf_sticky}, 0);
      check("midrst_op_count", op_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      last_acc = 4'h0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("postrst_out_valid", bus.out_valid, 0);
         check("postrst_sticky", ovf_sticky, 0);
      end

      // 256 ADDs: the completed-operation counter wraps to zero.
      apply_reset();
      mst = 1'b0;
      for (int i = 0; i < 256; i++) begin
         model_exec(last_acc, 4'h1, 1'b0, mr, mcf, mof);
         mst = mst | mof;
         push_exp(OP_ADD, 4'h1, mr, mcf, mof, mst, 8'((i + 1) % 256));
         drive_accept(OP_ADD, 4'h1);
         receive();
      end
      check("wrap_op_count", op_count, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
